// File: rtl/fpu_operand_sequencer.sv
// Operand stimulus source for the FP add/sub wrapper. Two Galois LFSRs supply A and B,
// with IEEE special values periodically substituted on A. The run is bounded and uses valid/ready.
module fpu_operand_sequencer #(
    parameter logic [31:0] SEED_A        = 32'hACE1_2468,
    parameter logic [31:0] SEED_B        = 32'h1357_9BDF,
    parameter int          NUM_OPS       = 256,
    parameter int          SPECIAL_EVERY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic        sub,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] op_count
);

    localparam int                 DATA_W      = 32;
    localparam logic [DATA_W-1:0]  LFSR_MASK   = 32'h8020_0003;
    localparam logic [DATA_W-1:0]  SEED_A_EFF  = (SEED_A == '0) ? 32'h0000_0001 : SEED_A;
    localparam logic [DATA_W-1:0]  SEED_B_EFF  = (SEED_B == '0) ? 32'h0000_0001 : SEED_B;
    localparam logic [15:0]        LAST_OP     = 16'(NUM_OPS - 1);
    localparam logic [15:0]        PERIOD      = 16'(SPECIAL_EVERY);
    localparam logic [15:0]        PERIOD_LAST = 16'(SPECIAL_EVERY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              load;
    logic              fire;
    logic [DATA_W-1:0] lfsr_a;
    logic [DATA_W-1:0] lfsr_b;
    logic [DATA_W-1:0] lfsr_a_step;
    logic [DATA_W-1:0] lfsr_b_step;
    logic [15:0]       count_inc;

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    // Every SPECIAL_EVERY-th slot replaces A with one of four IEEE corner values in rotation.
    function automatic logic [DATA_W-1:0] operand_a(input logic [15:0]       count,
                                                    input logic [DATA_W-1:0] lfsr);
        logic [DATA_W-1:0] result;
        result = lfsr;
        if ((count % PERIOD) == PERIOD_LAST) begin
            unique case (2'((count / PERIOD) % 16'd4))
                2'd0:    result = 32'h0000_0000;
                2'd1:    result = 32'h7F80_0000;
                2'd2:    result = 32'h7FC0_0000;
                default: result = 32'h0000_0001;
            endcase
        end
        return result;
    endfunction

    assign lfsr_a_step = lfsr_next(lfsr_a);
    assign lfsr_b_step = lfsr_next(lfsr_b);
    assign count_inc   = 16'(op_count + 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        fire       = 1'b0;
        valid      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                valid = 1'b1;
                busy  = 1'b1;
                if (ready) begin
                    fire = 1'b1;
                    if (op_count == LAST_OP) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand registers: preloaded for the next slot on each handshake, frozen after the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_a   <= SEED_A_EFF;
            lfsr_b   <= SEED_B_EFF;
            A        <= '0;
            B        <= '0;
            sub      <= 1'b0;
            op_count <= '0;
        end else if (load) begin
            lfsr_a   <= SEED_A_EFF;
            lfsr_b   <= SEED_B_EFF;
            A        <= operand_a(16'd0, SEED_A_EFF);
            B        <= SEED_B_EFF;
            sub      <= 1'b0;
            op_count <= '0;
        end else if (fire) begin
            lfsr_a   <= lfsr_a_step;
            lfsr_b   <= lfsr_b_step;
            sub      <= ~sub;
            op_count <= count_inc;
            if (op_count != LAST_OP) begin
                A <= operand_a(count_inc, lfsr_a_step);
                B <= lfsr_b_step;
            end
        end
    end

endmodule
